mem_port_arbiter: RTL and testbench

Parametrised multi-channel front end for the LPDDR user port (command/write/read FIFO interface of the memory controller core). It replaces single-word, single-client access with round-robin arbitration among NUM_CH clients. Each access is a burst of 1..MAX_BL words, reads or writes, and a stall watchdog guards every access. It sits between the image-processing clients and the controller, in the same clock domain as the controller user port.

---
 rtl/mem_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 23 ++
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding, controller command codes and helpers
// for the mem_port_arbiter front end.
package mem_pkg;
    typedef enum logic [2:0] {
        INIT, IDLE, WR_FILL, WR_CMD, WR_DRAIN, RD_CMD, RD_WAIT, RD_DRAIN
    } state_t;
    localparam logic [2:0] CMD_WRITE = 3'd0;
    localparam logic [2:0] CMD_READ = 3'd1;
    localparam logic [2:0] CMD_REFRESH = 3'd4;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or
// after ptr, wrapping modulo NUM_CH.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int IW = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IW-1:0]     idx,
    output logic              any
);
    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (req[(int'(ptr) + i) % NUM_CH]) idx = IW'((int'(ptr) + i) % NUM_CH);
    end
    assign any = |req;
    assign grant = any ? NUM_CH'(1) << idx : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin multi-channel burst front end for the
// LPDDR user port, with a per-phase stall watchdog.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18,
    parameter int MAX_BL = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     calib_done,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH-1:0]        req_we,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*6-1:0]      req_bl,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        wdata_ack,
    output logic [DATA_W-1:0]        rdata,
    output logic [NUM_CH-1:0]        rdata_valid,
    output logic                     cmd_en,
    output logic [2:0]               cmd_instr,
    output logic [5:0]               cmd_bl,
    output logic [29:0]              cmd_byte_addr,
    input  logic                     cmd_full,
    output logic                     wr_en,
    output logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W/8-1:0]      wr_mask,
    input  logic                     wr_full,
    input  logic                     wr_empty,
    output logic                     rd_en,
    input  logic [DATA_W-1:0]        rd_data,
    input  logic                     rd_empty,
    output logic                     busy,
    output logic                     timeout_err
);
    localparam int IW = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam int OFS = clog2(DATA_W / 8);
    localparam int TW = clog2(TIMEOUT + 1);

    state_t state, nxt;
    logic [IW-1:0] rr_ptr, g, a_idx;
    logic [NUM_CH-1:0] a_grant;
    logic a_any, hit, last;
    logic [ADDR_W-1:0] addr;
    logic [5:0] bl, words, a_bl;
    logic [TW-1:0] wd_cnt;
    logic [ADDR_W+OFS+29:0] byte_addr;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req(req_valid),
        .ptr(rr_ptr),
        .grant(a_grant),
        .idx(a_idx),
        .any(a_any)
    );

    assign a_bl = req_bl[int'(a_idx)*6 +: 6];
    assign busy = state != INIT && state != IDLE;
    // Watchdog expiry overrides every strobe in the same cycle.
    assign hit = busy && wd_cnt == TW'(TIMEOUT);
    assign last = words == bl;
    assign wr_en = state == WR_FILL && !wr_full && !hit;
    assign cmd_en = (state == WR_CMD || state == RD_CMD) && !cmd_full && !hit;
    assign rd_en = state == RD_DRAIN && !rd_empty && !hit;
    assign cmd_instr = state == RD_CMD ? CMD_READ : CMD_WRITE;
    assign cmd_bl = bl;
    assign byte_addr = {30'd0, addr, {OFS{1'b0}}};
    assign cmd_byte_addr = byte_addr[29:0];
    assign wr_data = wr_en ? wdata[int'(g)*DATA_W +: DATA_W] : '0;
    assign wr_mask = '0;
    assign wdata_ack = wr_en ? NUM_CH'(1) << g : '0;

    always_comb begin
        nxt = state;
        case (state)
            INIT:     nxt = calib_done ? IDLE : INIT;
            IDLE:     nxt = !a_any ? IDLE : req_we[a_idx] ? WR_FILL : RD_CMD;
            WR_FILL:  nxt = (wr_en && last) ? WR_CMD : WR_FILL;
            WR_CMD:   nxt = cmd_en ? WR_DRAIN : WR_CMD;
            WR_DRAIN: nxt = wr_empty ? IDLE : WR_DRAIN;
            RD_CMD:   nxt = cmd_en ? RD_WAIT : RD_CMD;
            RD_WAIT:  nxt = rd_empty ? RD_WAIT : RD_DRAIN;
            RD_DRAIN: nxt = (rd_en && last) ? IDLE : RD_DRAIN;
            default:  nxt = INIT;
        endcase
        if (hit) nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            rr_ptr <= '0;
            g <= '0;
            addr <= '0;
            bl <= '0;
            words <= '0;
            wd_cnt <= '0;
            req_ready <= '0;
            rdata <= '0;
            rdata_valid <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= nxt;
            wd_cnt <= (nxt != state || !busy) ? '0 : wd_cnt + TW'(1);
            words <= (nxt != state) ? '0 : (wr_en || rd_en) ? words + 6'd1 : words;
            req_ready <= (state == IDLE && a_any) ? a_grant : '0;
            rdata_valid <= rd_en ? NUM_CH'(1) << g : '0;
            if (rd_en) rdata <= rd_data;
            if (hit) timeout_err <= 1'b1;
            if (state == IDLE && a_any) begin
                g <= a_idx;
                addr <= req_addr[int'(a_idx)*ADDR_W +: ADDR_W];
                bl <= (a_bl > 6'(MAX_BL - 1)) ? 6'(MAX_BL - 1) : a_bl;
                rr_ptr <= IW'((int'(a_idx) + 1) % NUM_CH);
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench with a behavioural
// controller (FIFOs + DRAM array) and a client-level reference memory.
module tb_mem_port_arbiter;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int AW = 18;
    localparam int MBL = 8;
    localparam int TO = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic calib_done = 1'b0;
    logic [NC-1:0] req_valid = '0, req_we = '0;
    logic [NC-1:0] req_ready, wdata_ack, rdata_valid;
    logic [NC*AW-1:0] req_addr = '0;
    logic [NC*6-1:0] req_bl = '0;
    logic [NC*DW-1:0] wdata = '0;
    logic [DW-1:0] rdata, wr_data;
    logic [DW-1:0] rd_data = '0;
    logic cmd_en, wr_en, rd_en, busy, timeout_err;
    logic [2:0] cmd_instr;
    logic [5:0] cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic [DW/8-1:0] wr_mask;
    logic cmd_full = 1'b0, wr_full = 1'b0, wr_empty = 1'b1, rd_empty = 1'b1;

    mem_port_arbiter #(.NUM_CH(NC), .DATA_W(DW), .ADDR_W(AW), .MAX_BL(MBL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .calib_done(calib_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_bl(req_bl), .wdata(wdata), .wdata_ack(wdata_ack),
        .rdata(rdata), .rdata_valid(rdata_valid),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_full(wr_full), .wr_empty(wr_empty),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    bit rnd = 0, force_cf = 0, force_re = 0;
    logic [DW-1:0] wd [NC][64];
    int wi [NC], ackc [NC];
    int gq [$];
    logic [38:0] cq [$];
    logic [NC+DW-1:0] rq [$];
    logic [DW-1:0] wfifo [$], rfifo [$];
    logic [DW-1:0] dram [int];
    logic [DW-1:0] ref_mem [int];
    int ptr_m = 0;

    // One clock: drive inputs just after the edge, observe at the falling edge,
    // and let the controller model react to the strobes it saw.
    task automatic step();
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) wdata[c*DW +: DW] = wd[c][wi[c] % 64];
        cmd_full = force_cf || (rnd && $urandom_range(3) == 0);
        wr_full = rnd && $urandom_range(3) == 0;
        wr_empty = wfifo.size() == 0;
        rd_empty = force_re || rfifo.size() == 0 || (rnd && $urandom_range(3) == 0);
        rd_data = rfifo.size() > 0 ? rfifo[0] : 32'hDEADBEEF;
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            if (req_ready[c]) begin
                gq.push_back(c);
                req_valid[c] = 1'b0;
            end
            if (wdata_ack[c]) begin
                ackc[c]++;
                wi[c]++;
            end
        end
        if (wr_en) wfifo.push_back(wr_data);
        if (rdata_valid != '0) rq.push_back({rdata_valid, rdata});
        if (rd_en && rfifo.size() > 0) void'(rfifo.pop_front());
        if (cmd_en) begin
            cq.push_back({cmd_instr, cmd_bl, cmd_byte_addr});
            for (int i = 0; i <= int'(cmd_bl); i++) begin
                int a;
                a = int'(cmd_byte_addr >> 2) + i;
                if (cmd_instr == 3'd0) begin
                    if (wfifo.size() > 0) dram[a] = wfifo.pop_front();
                    else dram[a] = '0;
                end else rfifo.push_back(dram.exists(a) ? dram[a] : '0);
            end
        end
    endtask

    task automatic set_ch(input int c, input bit we, input int addr, input int bl);
        req_we[c] = we;
        req_addr[c*AW +: AW] = AW'(addr);
        req_bl[c*6 +: 6] = 6'(bl);
        for (int i = 0; i < 64; i++) wd[c][i] = $urandom;
    endtask

    task automatic clear();
        gq.delete();
        cq.delete();
        rq.delete();
        for (int c = 0; c < NC; c++) begin
            wi[c] = 0;
            ackc[c] = 0;
        end
    endtask

    task automatic do_reset(input bit calib);
        rst = 1'b1;
        calib_done = 1'b0;
        req_valid = '0;
        force_cf = 0;
        force_re = 0;
        rnd = 0;
        step();
        step();
        rst = 1'b0;
        wfifo.delete();
        rfifo.delete();
        ptr_m = 0;
        calib_done = calib;
        step();
        step();
    endtask

    task automatic run_batch(input logic [NC-1:0] mask);
        int n = 0;
        clear();
        req_valid = mask;
        while ((req_valid != '0 || busy) && n < 2000) begin
            step();
            n++;
        end
        repeat (3) step();
        total++;
        if (n >= 2000) begin
            bad++;
            $display("FAIL batch_bound steps=%0d limit=2000", n);
        end
    endtask

    task automatic test_reset();
        do_reset(0);
        clear();
        set_ch(0, 1, 0, 0);
        req_valid[0] = 1'b1;
        repeat (5) step();
        total++; if (gq.size() !== 0) begin bad++; $display("FAIL init_no_grant got=%0d want=0", gq.size()); end
        total++; if ({busy, cmd_en, wr_en, rd_en, timeout_err} !== 5'd0) begin bad++; $display("FAIL reset_strobes got=%b want=00000", {busy, cmd_en, wr_en, rd_en, timeout_err}); end
        total++; if ({req_ready, wdata_ack, rdata_valid} !== '0) begin bad++; $display("FAIL reset_onehots got=%h want=0", {req_ready, wdata_ack, rdata_valid}); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        total++; if ({cmd_instr, cmd_bl, cmd_byte_addr} !== 39'd0) begin bad++; $display("FAIL reset_cmd got=%h want=0", {cmd_instr, cmd_bl, cmd_byte_addr}); end
        total++; if ({wr_data, wr_mask} !== '0) begin bad++; $display("FAIL reset_wr got=%h want=0", {wr_data, wr_mask}); end
        req_valid = '0;
    endtask

    task automatic test_single_write_read();
        do_reset(1);
        set_ch(0, 1, 'h10, 3);
        for (int i = 0; i < 4; i++) wd[0][i] = 32'hA0 + i;
        run_batch(4'b0001);
        total++; if (ackc[0] !== 4) begin bad++; $display("FAIL single_acks got=%0d want=4", ackc[0]); end
        total++; if (gq.size() !== 1 || gq[0] !== 0) begin bad++; $display("FAIL single_grant got=%0d want=1 grant of ch0", gq.size()); end
        total++; if (cq.size() !== 1 || cq[0] !== {3'd0, 6'd3, 30'h40}) begin bad++; $display("FAIL single_wcmd got=%0d cmds want=1 cmd %h", cq.size(), {3'd0, 6'd3, 30'h40}); end
        set_ch(0, 0, 'h10, 3);
        run_batch(4'b0001);
        total++; if (cq.size() !== 1 || cq[0] !== {3'd1, 6'd3, 30'h40}) begin bad++; $display("FAIL single_rcmd got=%0d cmds want=1 cmd %h", cq.size(), {3'd1, 6'd3, 30'h40}); end
        total++; if (rq.size() !== 4) begin bad++; $display("FAIL single_rcount got=%0d want=4", rq.size()); end
        for (int i = 0; i < rq.size() && i < 4; i++) begin
            total++;
            if (rq[i] !== {4'b0001, 32'hA0 + i}) begin bad++; $display("FAIL single_rdata[%0d] got=%h want=%h", i, rq[i], {4'b0001, 32'hA0 + i}); end
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        do_reset(1);
        clear();
        for (int c = 0; c < NC; c++) set_ch(c, 1, 'h3000 + c * 16, 0);
        req_valid = '1;
        while (gq.size() < 5 && n < 500) begin
            step();
            req_valid = '1;
            n++;
        end
        req_valid = '0;
        while (busy && n < 600) begin
            step();
            n++;
        end
        repeat (3) step();
        total++; if (gq.size() < 5) begin bad++; $display("FAIL rr_count got=%0d want>=5", gq.size()); end
        for (int i = 0; i < 5 && i < gq.size(); i++) begin
            total++;
            if (gq[i] !== i % NC) begin bad++; $display("FAIL rr_order[%0d] got=%0d want=%0d", i, gq[i], i % NC); end
        end
    endtask

    task automatic test_cmd_full();
        int n = 0, seen = 0;
        do_reset(1);
        clear();
        set_ch(2, 1, 'h60, 4);
        req_valid[2] = 1'b1;
        while (ackc[2] < 5 && n < 100) begin
            step();
            n++;
        end
        force_cf = 1;
        repeat (10) begin
            step();
            if (cmd_en) seen++;
        end
        total++; if (seen !== 0 || ackc[2] !== 5) begin bad++; $display("FAIL cmdfull_hold got=%0d cmd/%0d acks want=0/5", seen, ackc[2]); end
        force_cf = 0;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        repeat (2) step();
        total++; if (cq.size() !== 1 || cq[0] !== {3'd0, 6'd4, 30'h180}) begin bad++; $display("FAIL cmdfull_pulse got=%0d cmds want=1 cmd %h", cq.size(), {3'd0, 6'd4, 30'h180}); end
    endtask

    task automatic test_clamp();
        logic [DW-1:0] exp_w [8];
        do_reset(1);
        set_ch(3, 1, 'h200, 63);
        for (int i = 0; i < 8; i++) exp_w[i] = wd[3][i];
        run_batch(4'b1000);
        total++; if (ackc[3] !== 8) begin bad++; $display("FAIL clamp_acks got=%0d want=8", ackc[3]); end
        total++; if (cq.size() !== 1 || cq[0][35:30] !== 6'd7) begin bad++; $display("FAIL clamp_bl got=%0d cmds want=1 with bl 7", cq.size()); end
        set_ch(3, 0, 'h200, 63);
        run_batch(4'b1000);
        total++; if (rq.size() !== 8) begin bad++; $display("FAIL clamp_rcount got=%0d want=8", rq.size()); end
        for (int i = 0; i < rq.size() && i < 8; i++) begin
            total++;
            if (rq[i] !== {4'b1000, exp_w[i]}) begin bad++; $display("FAIL clamp_rdata[%0d] got=%h want=%h", i, rq[i], {4'b1000, exp_w[i]}); end
        end
    endtask

    task automatic test_timeout();
        int n = 0, k = 0;
        do_reset(1);
        clear();
        set_ch(1, 0, 'h50, 2);
        force_re = 1;
        req_valid[1] = 1'b1;
        while (cq.size() == 0 && n < 50) begin
            step();
            n++;
        end
        while (!timeout_err && k < TO + 20) begin
            step();
            k++;
        end
        total++; if (k < TO || k > TO + 3) begin bad++; $display("FAIL timeout_delay got=%0d want=%0d..%0d", k, TO, TO + 3); end
        total++; if (rq.size() !== 0) begin bad++; $display("FAIL timeout_no_rdata got=%0d want=0", rq.size()); end
        force_re = 0;
        rfifo.delete();
        step();
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b want=0", busy); end
        set_ch(0, 1, 'h70, 1);
        run_batch(4'b0001);
        total++; if (gq.size() !== 1 || ackc[0] !== 2) begin bad++; $display("FAIL timeout_next got=%0d grants/%0d acks want=1/2", gq.size(), ackc[0]); end
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b want=1", timeout_err); end
        do_reset(1);
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_rst_clear got=%b want=0", timeout_err); end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        do_reset(1);
        clear();
        set_ch(0, 1, 'h400, 7);
        req_valid[0] = 1'b1;
        while (ackc[0] < 3 && n < 50) begin
            step();
            n++;
        end
        rst = 1'b1;
        calib_done = 1'b0;
        step();
        rst = 1'b0;
        total++; if ({busy, wr_en} !== 2'b00) begin bad++; $display("FAIL midrst_outputs got=%b want=00", {busy, wr_en}); end
        gq.delete();
        set_ch(1, 1, 'h410, 1);
        req_valid[1] = 1'b1;
        repeat (3) step();
        total++; if (gq.size() !== 0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_init got=%0d grants busy=%b want=0 grants busy=0", gq.size(), busy); end
        wfifo.delete();
        rfifo.delete();
        calib_done = 1'b1;
        run_batch(4'b0010);
        total++; if (gq.size() !== 1 || gq[0] !== 1 || ackc[1] !== 2) begin bad++; $display("FAIL midrst_fresh got=%0d grants/%0d acks want=1/2", gq.size(), ackc[1]); end
        total++; if (cq.size() !== 1 || cq[0] !== {3'd0, 6'd1, 30'h1040}) begin bad++; $display("FAIL midrst_cmd got=%0d cmds want=1 cmd %h", cq.size(), {3'd0, 6'd1, 30'h1040}); end
    endtask

    task automatic test_random();
        bit we_of [NC];
        int addr_of [NC], bl_of [NC];
        do_reset(1);
        rnd = 1;
        for (int it = 0; it < 25; it++) begin
            logic [NC-1:0] mask, pend;
            int ri = 0;
            mask = NC'($urandom_range(15, 1));
            for (int c = 0; c < NC; c++) begin
                we_of[c] = 1'($urandom_range(1));
                addr_of[c] = 'h100 + $urandom_range(31);
                bl_of[c] = $urandom_range(9);
                set_ch(c, we_of[c], addr_of[c], bl_of[c]);
            end
            run_batch(mask);
            pend = mask;
            for (int k = 0; pend != '0; k++) begin
                int g = 0, n;
                bit found = 0;
                for (int o = 0; o < NC; o++)
                    if (!found && pend[(ptr_m + o) % NC]) begin
                        g = (ptr_m + o) % NC;
                        found = 1;
                    end
                ptr_m = (g + 1) % NC;
                pend[g] = 1'b0;
                n = (bl_of[g] < MBL - 1 ? bl_of[g] : MBL - 1) + 1;
                total++;
                if (k >= gq.size() || gq[k] !== g) begin bad++; $display("FAIL rand_grant it=%0d k=%0d got=%0d want=%0d", it, k, k < gq.size() ? gq[k] : -1, g); end
                total++;
                if (k >= cq.size() || cq[k] !== {we_of[g] ? 3'd0 : 3'd1, 6'(n - 1), 30'(addr_of[g] * 4)})
                    begin bad++; $display("FAIL rand_cmd it=%0d k=%0d got=%h want=%h", it, k, k < cq.size() ? cq[k] : '0, {we_of[g] ? 3'd0 : 3'd1, 6'(n - 1), 30'(addr_of[g] * 4)}); end
                if (we_of[g]) begin
                    total++;
                    if (ackc[g] !== n) begin bad++; $display("FAIL rand_acks it=%0d ch=%0d got=%0d want=%0d", it, g, ackc[g], n); end
                    for (int i = 0; i < n; i++) ref_mem[addr_of[g] + i] = wd[g][i];
                end else begin
                    for (int i = 0; i < n; i++) begin
                        logic [NC+DW-1:0] e;
                        e = {NC'(1) << g, ref_mem.exists(addr_of[g] + i) ? ref_mem[addr_of[g] + i] : '0};
                        total++;
                        if (ri >= rq.size() || rq[ri] !== e) begin bad++; $display("FAIL rand_rdata it=%0d ch=%0d i=%0d got=%h want=%h", it, g, i, ri < rq.size() ? rq[ri] : '0, e); end
                        ri++;
                    end
                end
            end
            total++;
            if (rq.size() !== ri) begin bad++; $display("FAIL rand_extra_reads it=%0d got=%0d want=%0d", it, rq.size(), ri); end
        end
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rand_no_timeout got=%b want=0", timeout_err); end
        rnd = 0;
    endtask

    initial begin
        test_reset();
        test_single_write_read();
        test_round_robin();
        test_cmd_full();
        test_clamp();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_bound time=%0t limit=600000", $time);
        $fatal(1, "simulation bound expired");
    end
endmodule
